// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Instruction fetch stage. Owns the program counter, issues one instruction
//   memory request at a time and presents each fetched word to decode/execute.
//   Taken branches resolved downstream redirect fetch and squash the
//   wrong-path instruction (or the response to an in-flight wrong-path request).
//
// Parameters
//   N         PC / address width
//   RESET_PC  fetch address after reset (bits [1:0] must be 0)
//   PC_STEP   sequential increment in bytes
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   imem_req       request, held with imem_addr stable until imem_ack
//   imem_addr      word-aligned fetch address
//   imem_ack       response valid (only meaningful while imem_req=1)
//   imem_data      instruction word, valid with imem_ack
//   instruction    fetched instruction, valid with inst_valid
//   pc             address of instruction
//   inst_valid     instruction available downstream
//   inst_ready     downstream accepts (transfer = inst_valid & inst_ready)
//   branch_valid   downstream resolved a branch this cycle
//   branch_taken   branch condition true; ignored unless branch_valid
//   branch_target  redirect address
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned    N        = 64,
    parameter logic [N-1:0]   RESET_PC = '0,
    parameter logic [N-1:0]   PC_STEP  = N'(4)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_data,
    output logic [31:0]   instruction,
    output logic [N-1:0]  pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    input  logic          branch_valid,
    input  logic          branch_taken,
    input  logic [N-1:0]  branch_target
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;
    localparam logic [1:0] ST_SQUASH = 2'd3;

    localparam logic [N-1:0] ALIGN_MASK = ~{{(N-2){1'b0}}, 2'b11};

    logic [1:0]   state_q,    state_d;
    logic [N-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the wrong-path request still in flight while squashing;
    // fetch_pc may already hold the redirect target by then.
    logic [N-1:0] sq_addr_q,  sq_addr_d;
    logic [31:0]  instr_q,    instr_d;
    logic [N-1:0] pc_q,       pc_d;

    logic         redirect;
    logic [N-1:0] target_al;
    logic [N-1:0] addr_sel;

    assign redirect  = branch_valid & branch_taken;
    assign target_al = branch_target & ALIGN_MASK;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        sq_addr_d  = sq_addr_q;
        instr_d    = instr_q;
        pc_d       = pc_q;

        // A taken branch retargets fetch regardless of state.
        if (redirect) begin
            fetch_pc_d = target_al;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    // Response arriving with the redirect is wrong-path: drop it
                    // and request the target next cycle. Without an ack the
                    // outstanding request must still be allowed to complete.
                    if (!imem_ack) begin
                        state_d   = ST_SQUASH;
                        sq_addr_d = fetch_pc_q;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_data;
                    pc_d    = fetch_pc_q;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // Redirect wins over a simultaneous transfer.
                if (redirect) begin
                    state_d = ST_REQ;
                end else if (inst_ready) begin
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    state_d    = ST_REQ;
                end
            end
            ST_SQUASH: begin
                if (imem_ack) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            sq_addr_q  <= RESET_PC;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            sq_addr_q  <= sq_addr_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

    // Outputs decode from registered state only.
    assign addr_sel    = (state_q == ST_SQUASH) ? sq_addr_q : fetch_pc_q;
    assign imem_addr   = addr_sel & ALIGN_MASK;
    assign imem_req    = (state_q == ST_REQ) || (state_q == ST_SQUASH);
    assign inst_valid  = (state_q == ST_OUT);
    assign instruction = instr_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Self-checking bench for pc_fetch_unit. A transaction-level reference model
//   predicts the request/presentation outputs each cycle; a second instance
//   with a top-of-address-space reset PC covers wrap-around.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        imem_req, imem_ack, inst_valid, inst_ready;
    logic        branch_valid, branch_taken;
    logic [63:0] imem_addr, pc, branch_target;
    logic [31:0] imem_data, instruction;

    logic        w_imem_req, w_imem_ack, w_inst_valid, w_inst_ready;
    logic        w_branch_valid, w_branch_taken;
    logic [63:0] w_imem_addr, w_pc, w_branch_target;
    logic [31:0] w_imem_data, w_instruction;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return 32'h1022_0001 ^ (a[31:0] << 8) ^ a[63:32];
    endfunction

    assign imem_data   = mem_word(imem_addr);
    assign w_imem_data = mem_word(w_imem_addr);

    pc_fetch_unit #(.N(64), .RESET_PC(64'h0), .PC_STEP(64'd4)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instruction(instruction), .pc(pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .branch_valid(branch_valid), .branch_taken(branch_taken),
        .branch_target(branch_target)
    );

    pc_fetch_unit #(.N(64), .RESET_PC(WRAP_PC), .PC_STEP(64'd4)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(w_imem_ack), .imem_data(w_imem_data),
        .instruction(w_instruction), .pc(w_pc),
        .inst_valid(w_inst_valid), .inst_ready(w_inst_ready),
        .branch_valid(w_branch_valid), .branch_taken(w_branch_taken),
        .branch_target(w_branch_target)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: what has been asked of memory and what is on offer.
    bit          m_idle, m_req, m_squash, m_valid;
    logic [63:0] m_fetch, m_old, m_pc;
    logic [31:0] m_inst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idle   = 1'b1;
        m_req    = 1'b0;
        m_squash = 1'b0;
        m_valid  = 1'b0;
        m_fetch  = 64'h0;
        m_old    = 64'h0;
        m_pc     = 64'h0;
        m_inst   = 32'h0;
    endtask

    task automatic model_step();
        logic        redir;
        logic [63:0] tgt;
        if (rst) begin
            model_reset();
            return;
        end
        redir = branch_valid & branch_taken;
        tgt   = {branch_target[63:2], 2'b00};
        if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
            if (redir) m_fetch = tgt;
        end else if (m_req) begin
            if (imem_ack) begin
                if (redir) m_fetch = tgt;
                if (m_squash || redir) begin
                    m_squash = 1'b0;
                end else begin
                    m_req   = 1'b0;
                    m_valid = 1'b1;
                    m_pc    = m_fetch;
                    m_inst  = mem_word(m_fetch);
                end
            end else if (redir) begin
                if (!m_squash) begin
                    m_squash = 1'b1;
                    m_old    = m_fetch;
                end
                m_fetch = tgt;
            end
        end else if (m_valid) begin
            if (redir) begin
                m_fetch = tgt;
                m_valid = 1'b0;
                m_req   = 1'b1;
            end else if (inst_ready) begin
                m_fetch = m_fetch + 64'd4;
                m_valid = 1'b0;
                m_req   = 1'b1;
            end
        end
    endtask

    task automatic check_main();
        chk("imem_req", {63'b0, imem_req}, {63'b0, m_req});
        chk("addr_align", {62'b0, imem_addr[1:0]}, 64'h0);
        if (m_req) chk("imem_addr", imem_addr, m_squash ? m_old : m_fetch);
        chk("inst_valid", {63'b0, inst_valid}, {63'b0, m_valid});
        if (m_valid) begin
            chk("instruction", {32'b0, instruction}, {32'b0, m_inst});
            chk("pc", pc, m_pc);
        end
    endtask

    // Inputs are set at the falling edge by the caller; the model advances at
    // the rising edge and outputs are compared at the next falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_main();
    endtask

    task automatic drive(input logic a, input logic r, input logic bv, input logic bt,
                         input logic [63:0] t);
        imem_ack      = a;
        inst_ready    = r;
        branch_valid  = bv;
        branch_taken  = bt;
        branch_target = t;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        w_imem_ack = 1'b0; w_inst_ready = 1'b0;
        w_branch_valid = 1'b0; w_branch_taken = 1'b0; w_branch_target = 64'h0;
        model_reset();

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {63'b0, imem_req}, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_valid", {63'b0, inst_valid}, 64'h0);
        chk("rst_inst", {32'b0, instruction}, 64'h0);
        chk("rst_pc", pc, 64'h0);
        chk("rst_w_addr", w_imem_addr, WRAP_PC);
        rst = 1'b0;

        // First fetch
        tick();
        chk("first_req", {63'b0, imem_req}, 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("first_inst", {32'b0, instruction}, 64'h1022_0001);

        // Backpressure, then sequential stream
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        repeat (3) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0); tick();
        chk("seq_addr4", imem_addr, 64'h4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0); tick();
        chk("seq_addr8", imem_addr, 64'h8);

        // Advance to pc=0x10 on offer
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0); tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        chk("at_pc10", pc, 64'h10);

        // Taken branch from OUT with inst_ready high
        drive(1'b0, 1'b1, 1'b1, 1'b1, 64'h24); tick();
        chk("tk_addr", imem_addr, 64'h24);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        chk("tk_pc", pc, 64'h24);

        // Not-taken branch: target ignored
        drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h40); tick();
        chk("nt_addr", imem_addr, 64'h28);

        // Ack+redirect same cycle drops data, then redirect during wait
        drive(1'b1, 1'b0, 1'b1, 1'b1, 64'h8); tick();
        chk("rd_addr8", imem_addr, 64'h8);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 64'h101); tick();
        chk("sq_hold1", imem_addr, 64'h8);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        chk("sq_hold2", imem_addr, 64'h8);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0); tick();
        chk("sq_novalid", {63'b0, inst_valid}, 64'h0);
        chk("sq_target", imem_addr, 64'h100);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [63:0] t;
            t = ($urandom_range(0, 1) == 0) ? {56'h0, 8'($urandom)}
                                            : {32'($urandom), 32'($urandom)};
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 2), 1'($urandom_range(0, 1)), t);
            tick();
        end

        // Wrap-around instance, with reset pulse for both
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("w_req", {63'b0, w_imem_req}, 64'h1);
        chk("w_addr", w_imem_addr, WRAP_PC);
        w_imem_ack = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("w_pc", w_pc, WRAP_PC);
        chk("w_valid", {63'b0, w_inst_valid}, 64'h1);
        w_imem_ack = 1'b0; w_inst_ready = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        chk("w_wrap_addr", w_imem_addr, 64'h0);
        w_inst_ready = 1'b0;
        tick();

        // Asynchronous reset mid-wait: outputs drop before the next edge
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("ar_valid", {63'b0, inst_valid}, 64'h0);
        chk("ar_req", {63'b0, imem_req}, 64'h0);
        chk("ar_w_req", {63'b0, w_imem_req}, 64'h0);
        chk("ar_w_valid", {63'b0, w_inst_valid}, 64'h0);
        chk("ar_w_addr", w_imem_addr, WRAP_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
